// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared states, framing constants and parity helper for the HDR-DDR target decoder
package ddr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PRE,
        ST_WORD,
        ST_CRC,
        ST_SKIP
    } ddr_state_t;

    localparam logic [1:0] PRE_CMD   = 2'b01;
    localparam logic [1:0] PRE_DATA  = 2'b10;
    localparam logic [3:0] CRC_TOKEN = 4'hC;
    localparam logic [4:0] CRC5_INIT = 5'h1F;

    localparam logic [2:0] ERR_CMD_PRE   = 3'd1;
    localparam logic [2:0] ERR_PARITY    = 3'd2;
    localparam logic [2:0] ERR_DATA_PRE  = 3'd3;
    localparam logic [2:0] ERR_CRC_TOKEN = 3'd4;
    localparam logic [2:0] ERR_CRC       = 3'd5;
    localparam logic [2:0] ERR_ABORT     = 3'd6;

    // Returns {P1, P0}: P1 covers odd payload bits, P0 the even bits inverted.
    function automatic logic [1:0] ddr_parity(input logic [15:0] p);
        logic odd_par;
        logic even_par;
        odd_par  = 1'b0;
        even_par = 1'b1;
        for (int i = 0; i < 8; i++) begin
            odd_par  = odd_par ^ p[2*i+1];
            even_par = even_par ^ p[2*i];
        end
        return {odd_par, even_par};
    endfunction

endpackage

// File: rtl/ddr_crc5.sv
// rtl/ddr_crc5.sv - serial CRC5 (x^5+x^2+1) over received payload bits
module ddr_crc5
    import ddr_pkg::*;
(
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_din,
    output logic [4:0] o_crc
);

    logic fb;

    assign fb = o_crc[4] ^ i_din;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst || i_clr) begin
            o_crc <= CRC5_INIT;
        end else if (i_en) begin
            o_crc <= {o_crc[3:0], 1'b0} ^ {2'b00, fb, 1'b0, fb};
        end
    end

endmodule

// File: rtl/ddr_ccc_target_decoder.sv
// rtl/ddr_ccc_target_decoder.sv - HDR-DDR target receiver: frames words, decodes CCC/private writes, checks parity and CRC5
module ddr_ccc_target_decoder
    import ddr_pkg::*;
#(
    parameter logic [6:0] BCAST_ADDR = 7'h7E,
    parameter int         WCNT_W     = 8
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_en,
    input  logic              i_scl_pos_edge,
    input  logic              i_scl_neg_edge,
    input  logic              i_sda,
    input  logic [6:0]        i_dyn_addr,
    input  logic              i_hdr_restart,
    input  logic              i_hdr_exit,
    output logic              o_ccc_valid,
    output logic [7:0]        o_ccc_value,
    output logic [7:0]        o_ccc_db,
    output logic              o_data_valid,
    output logic [15:0]       o_data,
    output logic [WCNT_W-1:0] o_word_cnt,
    output logic              o_read_req,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_err_code
);

    ddr_state_t  state;
    logic [4:0]  bit_cnt;
    logic [18:0] shreg;
    logic [19:0] sh_next;
    logic        ccc_pending;
    logic        strobe;
    logic        abort;
    logic        parity_ok;
    logic [6:0]  cmd_addr;
    logic        cmd_rnw;
    logic        addr_hit;
    logic        crc_clr;
    logic        crc_en;
    logic [4:0]  crc_val;

    assign strobe    = i_scl_pos_edge | i_scl_neg_edge;
    assign abort     = i_hdr_exit | i_hdr_restart;
    // The last 18 bits of any word are payload[15:0] followed by {P1, P0}.
    assign sh_next   = {shreg, i_sda};
    assign parity_ok = (ddr_parity(sh_next[17:2]) == sh_next[1:0]);
    assign cmd_rnw   = sh_next[17];
    assign cmd_addr  = sh_next[9:3];
    assign addr_hit  = (cmd_addr == BCAST_ADDR) || (cmd_addr == i_dyn_addr);

    // CRC sits at init for the whole command word, so every transaction start reseeds it.
    assign crc_clr = (state == ST_CMD);
    assign crc_en  = i_en && (state == ST_WORD) && strobe && !abort && (bit_cnt < 5'd16);

    ddr_crc5 u_crc5 (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .i_clr     (crc_clr),
        .i_en      (crc_en),
        .i_din     (i_sda),
        .o_crc     (crc_val)
    );

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            ccc_pending  <= 1'b0;
            o_ccc_valid  <= 1'b0;
            o_ccc_value  <= '0;
            o_ccc_db     <= '0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_word_cnt   <= '0;
            o_read_req   <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_err_code   <= '0;
        end else begin
            o_ccc_valid  <= 1'b0;
            o_data_valid <= 1'b0;
            o_read_req   <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            if (!i_en) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state       <= ST_CMD;
                        bit_cnt     <= '0;
                        o_word_cnt  <= '0;
                        ccc_pending <= 1'b0;
                    end
                    ST_SKIP: begin
                        if (i_hdr_restart) begin
                            state       <= ST_CMD;
                            bit_cnt     <= '0;
                            o_word_cnt  <= '0;
                            ccc_pending <= 1'b0;
                        end else if (i_hdr_exit) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        if (abort) begin
                            o_err      <= 1'b1;
                            o_err_code <= ERR_ABORT;
                            bit_cnt    <= '0;
                            if (i_hdr_exit) begin
                                state <= ST_IDLE;
                            end else begin
                                state       <= ST_CMD;
                                o_word_cnt  <= '0;
                                ccc_pending <= 1'b0;
                            end
                        end else if (strobe) begin
                            shreg   <= sh_next[18:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            case (state)
                                ST_CMD: if (bit_cnt == 5'd19) begin
                                    bit_cnt <= '0;
                                    if (sh_next[19:18] != PRE_CMD) begin
                                        o_err      <= 1'b1;
                                        o_err_code <= ERR_CMD_PRE;
                                        state      <= ST_SKIP;
                                    end else if (!parity_ok) begin
                                        o_err      <= 1'b1;
                                        o_err_code <= ERR_PARITY;
                                        state      <= ST_SKIP;
                                    end else if (!addr_hit) begin
                                        state <= ST_SKIP;
                                    end else if (cmd_rnw) begin
                                        o_read_req <= 1'b1;
                                        state      <= ST_SKIP;
                                    end else begin
                                        ccc_pending <= (cmd_addr == BCAST_ADDR);
                                        state       <= ST_PRE;
                                    end
                                end
                                ST_PRE: if (bit_cnt == 5'd1) begin
                                    bit_cnt <= '0;
                                    if (sh_next[1:0] == PRE_DATA) begin
                                        state <= ST_WORD;
                                    end else if (sh_next[1:0] == PRE_CMD && !ccc_pending) begin
                                        state <= ST_CRC;
                                    end else begin
                                        o_err      <= 1'b1;
                                        o_err_code <= ERR_DATA_PRE;
                                        state      <= ST_SKIP;
                                    end
                                end
                                ST_WORD: if (bit_cnt == 5'd17) begin
                                    bit_cnt <= '0;
                                    if (!parity_ok) begin
                                        o_err      <= 1'b1;
                                        o_err_code <= ERR_PARITY;
                                        state      <= ST_SKIP;
                                    end else if (ccc_pending) begin
                                        o_ccc_valid <= 1'b1;
                                        o_ccc_value <= sh_next[17:10];
                                        o_ccc_db    <= sh_next[9:2];
                                        ccc_pending <= 1'b0;
                                        state       <= ST_PRE;
                                    end else begin
                                        o_data_valid <= 1'b1;
                                        o_data       <= sh_next[17:2];
                                        if (!(&o_word_cnt)) begin
                                            o_word_cnt <= o_word_cnt + WCNT_W'(1);
                                        end
                                        state <= ST_PRE;
                                    end
                                end
                                ST_CRC: if (bit_cnt == 5'd8) begin
                                    bit_cnt <= '0;
                                    state   <= ST_SKIP;
                                    if (sh_next[8:5] != CRC_TOKEN) begin
                                        o_err      <= 1'b1;
                                        o_err_code <= ERR_CRC_TOKEN;
                                    end else if (sh_next[4:0] != crc_val) begin
                                        o_err      <= 1'b1;
                                        o_err_code <= ERR_CRC;
                                    end else begin
                                        o_done <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr_ccc_target_decoder.sv
// tb/tb_ddr_ccc_target_decoder.sv - table-driven scoreboard bench for the HDR-DDR target decoder
module tb_ddr_ccc_target_decoder;

    logic        i_sys_clk_tb = 1'b0;
    logic        i_sys_rst = 1'b1;
    logic        i_en = 1'b0;
    logic        i_scl_pos_edge = 1'b0;
    logic        i_scl_neg_edge = 1'b0;
    logic        i_sda = 1'b0;
    logic [6:0]  i_dyn_addr = 7'h08;
    logic        i_hdr_restart = 1'b0;
    logic        i_hdr_exit = 1'b0;
    logic        o_ccc_valid;
    logic [7:0]  o_ccc_value;
    logic [7:0]  o_ccc_db;
    logic        o_data_valid;
    logic [15:0] o_data;
    logic [7:0]  o_word_cnt;
    logic        o_read_req;
    logic        o_done;
    logic        o_err;
    logic [2:0]  o_err_code;

    ddr_ccc_target_decoder dut (
        .i_sys_clk      (i_sys_clk_tb),
        .i_sys_rst      (i_sys_rst),
        .i_en           (i_en),
        .i_scl_pos_edge (i_scl_pos_edge),
        .i_scl_neg_edge (i_scl_neg_edge),
        .i_sda          (i_sda),
        .i_dyn_addr     (i_dyn_addr),
        .i_hdr_restart  (i_hdr_restart),
        .i_hdr_exit     (i_hdr_exit),
        .o_ccc_valid    (o_ccc_valid),
        .o_ccc_value    (o_ccc_value),
        .o_ccc_db       (o_ccc_db),
        .o_data_valid   (o_data_valid),
        .o_data         (o_data),
        .o_word_cnt     (o_word_cnt),
        .o_read_req     (o_read_req),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_err_code     (o_err_code)
    );

    always #5 i_sys_clk_tb = ~i_sys_clk_tb;

    localparam logic [4:0] K_READ = 5'b10000;
    localparam logic [4:0] K_CCC  = 5'b01000;
    localparam logic [4:0] K_DATA = 5'b00100;
    localparam logic [4:0] K_DONE = 5'b00010;
    localparam logic [4:0] K_ERR  = 5'b00001;

    typedef struct packed {
        logic [4:0]  kind;
        logic [15:0] value;
    } ev_t;

    typedef struct {
        bit              use_restart;
        logic [6:0]      dyn;
        logic [1:0]      cmd_pre;
        logic            rnw;
        logic [6:0]      addr;
        int              nwords;
        logic [2:0][15:0] words;
        int              bad_idx;
        logic [4:0]      crc_xor;
        bit              garbage;
    } vec_t;

    ev_t   exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    strobe_sel = 0;
    logic [2:0] exp_code = 3'd0;
    vec_t  vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [1:0] tb_parity(input logic [15:0] p);
        return {^(p & 16'hAAAA), ~^(p & 16'h5555)};
    endfunction

    function automatic logic [4:0] tb_crc(input logic [4:0] c_in, input logic [15:0] w);
        logic [4:0] c;
        c = c_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[4] ^ w[i]) c = {c[3:0], 1'b0} ^ 5'h05;
            else             c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    function automatic vec_t mk(input bit rs, input logic [6:0] dyn, input logic [1:0] pre,
                                input logic rnw, input logic [6:0] addr, input int nw,
                                input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                                input int bad, input logic [4:0] cx, input bit gb);
        vec_t v;
        v.use_restart = rs; v.dyn = dyn; v.cmd_pre = pre; v.rnw = rnw; v.addr = addr;
        v.nwords = nw; v.words = {w2, w1, w0}; v.bad_idx = bad; v.crc_xor = cx; v.garbage = gb;
        return v;
    endfunction

    task automatic push(input logic [4:0] k, input logic [15:0] val);
        ev_t e;
        e.kind = k;
        e.value = val;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge i_sys_clk_tb);
        #1;
    endtask

    // Rotates pos, neg and simultaneous strobes; each bit is followed by an idle cycle.
    task automatic send_bits(input logic [19:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            i_sda = v[i];
            i_scl_pos_edge = (strobe_sel != 1);
            i_scl_neg_edge = (strobe_sel != 0);
            strobe_sel = (strobe_sel + 1) % 3;
            tick();
            i_scl_pos_edge = 1'b0;
            i_scl_neg_edge = 1'b0;
            tick();
        end
    endtask

    task automatic start_en;
        i_en = 1'b0;
        tick();
        i_en = 1'b1;
        tick();
    endtask

    task automatic settle(input string tag);
        repeat (3) tick();
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [15:0] cmd;
        logic [15:0] w;
        logic [4:0]  crc;
        logic        is_ccc;
        logic        hit;
        bit          bad_hit;
        int          cnt;
        cnt = 0;
        bad_hit = 0;
        i_dyn_addr = v.dyn;
        if (v.use_restart) begin
            i_hdr_restart = 1'b1;
            tick();
            i_hdr_restart = 1'b0;
        end else begin
            start_en();
        end
        cmd = {v.rnw, 7'h00, v.addr, 1'b0};
        is_ccc = (v.addr == 7'h7E);
        hit = is_ccc || (v.addr == v.dyn);
        if (v.cmd_pre != 2'b01) begin
            push(K_ERR, 16'd1);
            exp_code = 3'd1;
        end else if (hit && v.rnw) begin
            push(K_READ, 16'h0);
        end
        send_bits({v.cmd_pre, cmd, tb_parity(cmd)}, 20);
        if (v.cmd_pre == 2'b01 && hit && !v.rnw) begin
            crc = 5'h1F;
            for (int i = 0; i < v.nwords && !bad_hit; i++) begin
                w = v.words[i];
                send_bits(20'h2, 2);
                if (i == v.bad_idx) begin
                    bad_hit = 1;
                    push(K_ERR, 16'd2);
                    exp_code = 3'd2;
                    send_bits({2'b00, w, tb_parity(w) ^ 2'b01}, 18);
                end else begin
                    if (i == 0 && is_ccc) begin
                        push(K_CCC, w);
                    end else begin
                        cnt++;
                        push(K_DATA, w);
                    end
                    crc = tb_crc(crc, w);
                    send_bits({2'b00, w, tb_parity(w)}, 18);
                end
            end
            if (!bad_hit) begin
                if (v.crc_xor == 5'd0) begin
                    push(K_DONE, 16'h0);
                end else begin
                    push(K_ERR, 16'd5);
                    exp_code = 3'd5;
                end
                send_bits(20'h1, 2);
                send_bits({11'h000, 4'hC, crc ^ v.crc_xor}, 9);
            end
        end
        if (v.garbage) send_bits(20'h6A5F3, 20);
        settle($sformatf("vec%0d", idx));
        check($sformatf("vec%0d_word_cnt", idx), 32'(o_word_cnt), 32'(cnt));
        check($sformatf("vec%0d_err_code", idx), 32'(o_err_code), 32'(exp_code));
    endtask

    // Scoreboard: every output pulse must match the oldest expected event.
    always @(negedge i_sys_clk_tb) begin
        logic [4:0]  sig;
        logic [15:0] val;
        ev_t e;
        if (!i_sys_rst) begin
            sig = {o_read_req, o_ccc_valid, o_data_valid, o_done, o_err};
            if (sig != 5'b0) begin
                if (o_ccc_valid)       val = {o_ccc_value, o_ccc_db};
                else if (o_data_valid) val = o_data;
                else if (o_err)        val = {13'h0, o_err_code};
                else                   val = 16'h0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got kind %b value %h, expected no event", sig, val);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(sig), 32'(e.kind));
                    check("event_value", 32'(val), 32'(e.value));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(0, 7'h08, 2'b01, 0, 7'h7E, 1, 16'h0100, 16'h0, 16'h0, -1, 5'h00, 0);
        vecs[1] = mk(0, 7'h08, 2'b01, 0, 7'h08, 3, 16'hA5A5, 16'h1234, 16'hFFFF, -1, 5'h00, 0);
        vecs[2] = mk(0, 7'h08, 2'b01, 0, 7'h08, 3, 16'h1111, 16'h2222, 16'h3333, 1, 5'h00, 0);
        vecs[3] = mk(0, 7'h08, 2'b01, 0, 7'h08, 1, 16'h5A5A, 16'h0, 16'h0, -1, 5'h01, 1);
        vecs[4] = mk(1, 7'h08, 2'b01, 0, 7'h09, 1, 16'h7777, 16'h0, 16'h0, -1, 5'h00, 0);
        vecs[5] = mk(1, 7'h08, 2'b01, 0, 7'h7E, 2, 16'h0203, 16'hBEEF, 16'h0, -1, 5'h00, 0);
        vecs[6] = mk(0, 7'h08, 2'b01, 1, 7'h08, 0, 16'h0, 16'h0, 16'h0, -1, 5'h00, 0);
        vecs[7] = mk(0, 7'h21, 2'b01, 1, 7'h7E, 0, 16'h0, 16'h0, 16'h0, -1, 5'h00, 0);
        vecs[8] = mk(0, 7'h08, 2'b10, 0, 7'h08, 0, 16'h0, 16'h0, 16'h0, -1, 5'h00, 0);
        vecs[9] = mk(0, 7'h08, 2'b01, 1, 7'h33, 0, 16'h0, 16'h0, 16'h0, -1, 5'h00, 0);

        repeat (3) tick();
        check("reset_pulses", 32'({o_read_req, o_ccc_valid, o_data_valid, o_done, o_err}), 32'd0);
        check("reset_regs", {o_ccc_value, o_ccc_db, o_data}, 32'd0);
        check("reset_cnt_code", 32'({o_word_cnt, o_err_code}), 32'd0);
        i_sys_rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Data preamble 2'b00 after a private-write command.
        start_en();
        push(K_ERR, 16'd3);
        exp_code = 3'd3;
        send_bits({2'b01, 16'h0010, tb_parity(16'h0010)}, 20);
        send_bits(20'h0, 2);
        settle("data_pre_00");
        check("data_pre_00_code", 32'(o_err_code), 32'(exp_code));

        // CRC preamble while the CCC word is still owed.
        start_en();
        push(K_ERR, 16'd3);
        send_bits({2'b01, 16'h00FC, tb_parity(16'h00FC)}, 20);
        send_bits(20'h1, 2);
        settle("ccc_crc_early");

        // Exit arrives together with a strobe mid-word: abort wins.
        start_en();
        send_bits({2'b01, 16'h0010, tb_parity(16'h0010)}, 20);
        send_bits(20'h2, 2);
        send_bits(20'hAB, 8);
        push(K_ERR, 16'd6);
        exp_code = 3'd6;
        i_sda = 1'b1;
        i_hdr_exit = 1'b1;
        i_scl_pos_edge = 1'b1;
        tick();
        i_hdr_exit = 1'b0;
        i_scl_pos_edge = 1'b0;
        settle("abort_exit");
        check("abort_exit_code", 32'(o_err_code), 32'(exp_code));

        run_vec(10, vecs[1]);

        // Reset in the middle of a command word.
        start_en();
        send_bits({2'b01, 16'h0010, tb_parity(16'h0010)} >> 10, 10);
        i_sys_rst = 1'b1;
        tick();
        check("midrst_pulses", 32'({o_read_req, o_ccc_valid, o_data_valid, o_done, o_err}), 32'd0);
        check("midrst_regs", {o_ccc_value, o_ccc_db, o_data}, 32'd0);
        check("midrst_cnt_code", 32'({o_word_cnt, o_err_code}), 32'd0);
        i_sys_rst = 1'b0;
        tick();
        send_bits(20'h003FF, 10);
        settle("midrst_tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
